reg_file_2r2w: RTL and testbench

- Parametrised successor to the processor's single-port register stack.
- Provides 2 combinational read ports (srcA/srcB) and 2 clocked write ports (dstE/dstM), matching the SEQ decode and write-back stages.
- Adds async reset to a defined state, a "no register" address encoding, and a fixed write-port priority.
- Adds a sticky write-collision status flag and an optional same-cycle write-to-read bypass.

---
 rtl/reg_file_2r2w.sv | 114 +++++++++++
 tb/tb_reg_file_2r2w.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r2w.sv
// Two-read / two-write register file with async reset, "no register" address and sticky collision flag.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_2r2w #(
    parameter int unsigned              DATA_W    = 64,
    parameter int unsigned              ADDR_W    = 4,
    parameter int unsigned              NUM_REGS  = 15,
    parameter logic [ADDR_W-1:0]        NONE_ADDR = 4'hF,
    parameter int unsigned              SP_IDX    = 4,
    parameter logic [DATA_W-1:0]        SP_INIT   = 64'h0000_0000_0000_0200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              wr_en,
    output logic              collide,
    input  logic              collide_clr
);

    localparam logic [ADDR_W-1:0] NumRegsA = ADDR_W'(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_collide;

    logic w_srca_ok;
    logic w_srcb_ok;
    logic w_dste_ok;
    logic w_dstm_ok;
    logic w_collide_set;

    // NONE_ADDR is excluded explicitly so it stays "no register" even if it were in range.
    assign w_srca_ok = (srcA < NumRegsA) && (srcA != NONE_ADDR);
    assign w_srcb_ok = (srcB < NumRegsA) && (srcB != NONE_ADDR);
    assign w_dste_ok = (dstE < NumRegsA) && (dstE != NONE_ADDR);
    assign w_dstm_ok = (dstM < NumRegsA) && (dstM != NONE_ADDR);

    assign w_collide_set = wr_en && w_dste_ok && (dstE == dstM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= (i == int'(SP_IDX)) ? SP_INIT : '0;
            end
        end else if (wr_en) begin
            // Port M is checked first so it wins when both ports target the same register.
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_dstm_ok && (dstM == ADDR_W'(i))) begin
                    r_regs[i] <= valM;
                end else if (w_dste_ok && (dstE == ADDR_W'(i))) begin
                    r_regs[i] <= valE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collide <= 1'b0;
        end else if (collide_clr) begin
            r_collide <= 1'b0;
        end else if (w_collide_set) begin
            r_collide <= 1'b1;
        end
    end

    logic [DATA_W-1:0] w_stored_a;
    logic [DATA_W-1:0] w_stored_b;

    always_comb begin
        w_stored_a = '0;
        w_stored_b = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_srca_ok && (srcA == ADDR_W'(i))) begin
                w_stored_a = r_regs[i];
            end
            if (w_srcb_ok && (srcB == ADDR_W'(i))) begin
                w_stored_b = r_regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        valA = w_stored_a;
        valB = w_stored_b;
        if (wr_en && w_srca_ok) begin
            if (w_dstm_ok && (srcA == dstM)) begin
                valA = valM;
            end else if (w_dste_ok && (srcA == dstE)) begin
                valA = valE;
            end
        end
        if (wr_en && w_srcb_ok) begin
            if (w_dstm_ok && (srcB == dstM)) begin
                valB = valM;
            end else if (w_dste_ok && (srcB == dstE)) begin
                valB = valE;
            end
        end
    end
`else
    assign valA = w_stored_a;
    assign valB = w_stored_b;
`endif

    assign collide = r_collide;

endmodule

// File: tb/tb_reg_file_2r2w.sv
// Scoreboard bench for reg_file_2r2w: stimulus queues expected values, a negedge monitor pops and checks.
module tb_reg_file_2r2w;

    logic        clk;
    logic        rst_n;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, valE, valM;
    logic        wr_en, collide, collide_clr;

    int n_tests;
    int n_fail;

    string       q_name [$];
    int          q_sel  [$];
    logic [63:0] q_exp  [$];
    logic        chk;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    reg_file_2r2w dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .srcA        (srcA),
        .srcB        (srcB),
        .valA        (valA),
        .valB        (valB),
        .dstE        (dstE),
        .valE        (valE),
        .dstM        (dstM),
        .valM        (valM),
        .wr_en       (wr_en),
        .collide     (collide),
        .collide_clr (collide_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: when the stimulus marks a sample point, drain the queue against the live outputs.
    always @(negedge clk) begin
        if (chk) begin
            while (q_sel.size() > 0) begin
                string       nm;
                int          sel;
                logic [63:0] ex;
                logic [63:0] got;
                nm  = q_name.pop_front();
                sel = q_sel.pop_front();
                ex  = q_exp.pop_front();
                case (sel)
                    0:       got = valA;
                    1:       got = valB;
                    default: got = {63'd0, collide};
                endcase
                n_tests++;
                if (got !== ex) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, got, ex);
                end
            end
        end
    end

    task automatic expect_val(input string nm, input int sel, input logic [63:0] ex);
        q_name.push_back(nm);
        q_sel.push_back(sel);
        q_exp.push_back(ex);
    endtask

    task automatic sample();
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] e, input logic [63:0] ve,
                      input logic [3:0] m, input logic [63:0] vm);
        dstE = e; valE = ve; dstM = m; valM = vm; wr_en = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0; chk = 1'b0;
        rst_n = 1'b0; srcA = 0; srcB = 0; dstE = 4'hF; dstM = 4'hF;
        valE = 0; valM = 0; wr_en = 1'b0; collide_clr = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        // Reset state
        srcA = 4; srcB = 0;
        expect_val("rst_sp", 0, 64'h200);
        expect_val("rst_r0", 1, 64'h0);
        expect_val("rst_collide", 2, 64'h0);
        sample();

        // Populate reg2 with a colliding write so the flag is set before the reset test
        tick();
        wr(4'd2, 64'h22, 4'd2, 64'h23);
        tick();
        wr_en = 1'b0; srcA = 2;
        expect_val("pre_rst_r2", 0, 64'h23);
        expect_val("pre_rst_collide", 2, 64'h1);
        sample();

        // Mid-cycle reset with a pending write to reg2
        tick();
        wr(4'd2, 64'h99, 4'hF, 64'h0);
        srcA = 2; srcB = 4;
        #2 rst_n = 1'b0;
        expect_val("midrst_r2", 0, 64'h0);
        expect_val("midrst_sp", 1, 64'h200);
        expect_val("midrst_collide", 2, 64'h0);
        sample();
        tick();
        wr_en = 1'b0;
        #1 rst_n = 1'b1;
        srcB = 0;
        expect_val("postrst_r2", 0, 64'h0);
        expect_val("postrst_r0", 1, 64'h0);
        sample();

        // Dual write to distinct registers
        tick();
        wr(4'd1, 64'h11, 4'd3, 64'h33);
        tick();
        wr_en = 1'b0; srcA = 1; srcB = 3;
        expect_val("dual_r1", 0, 64'h11);
        expect_val("dual_r3", 1, 64'h33);
        expect_val("dual_collide", 2, 64'h0);
        sample();

        // Collision: port M wins, flag set
        tick();
        wr(4'd5, 64'hAA, 4'd5, 64'hBB);
        tick();
        wr_en = 1'b0; srcA = 5;
        expect_val("coll_r5", 0, 64'hBB);
        expect_val("coll_flag", 2, 64'h1);
        sample();
        tick();
        collide_clr = 1'b1;
        tick();
        collide_clr = 1'b0;
        expect_val("clr_flag", 2, 64'h0);
        sample();

        // Clear beats a same-cycle collision
        tick();
        collide_clr = 1'b1;
        wr(4'd5, 64'hC1, 4'd5, 64'hC2);
        tick();
        collide_clr = 1'b0; wr_en = 1'b0;
        expect_val("clrwin_flag", 2, 64'h0);
        expect_val("clrwin_r5", 0, 64'hC2);
        sample();

        // NONE_ADDR writes are dropped and never collide
        tick();
        wr(4'hF, 64'hDEAD, 4'hF, 64'hBEEF);
        tick();
        wr_en = 1'b0; srcA = 4'hF; srcB = 1;
        expect_val("none_rd", 0, 64'h0);
        expect_val("none_r1", 1, 64'h11);
        expect_val("none_collide", 2, 64'h0);
        sample();

        // wr_en=0 blocks writes and collision setting
        tick();
        wr(4'd6, 64'h66, 4'd6, 64'h67);
        wr_en = 1'b0;
        tick();
        srcA = 6;
        expect_val("wroff_r6", 0, 64'h0);
        expect_val("wroff_collide", 2, 64'h0);
        sample();

        // Bypass: same-cycle visibility depends on build
        tick();
        wr(4'd7, 64'h77, 4'd8, 64'h88);
        srcA = 7; srcB = 8;
        expect_val("byp_pre_a", 0, Bypass ? 64'h77 : 64'h0);
        expect_val("byp_pre_b", 1, Bypass ? 64'h88 : 64'h0);
        sample();
        tick();
        wr_en = 1'b0;
        expect_val("byp_post_a", 0, 64'h77);
        expect_val("byp_post_b", 1, 64'h88);
        sample();

        // Bypass priority follows write priority
        tick();
        wr(4'd9, 64'h91, 4'd9, 64'h92);
        srcA = 9; srcB = 4'hF;
        expect_val("bypprio_pre", 0, Bypass ? 64'h92 : 64'h0);
        expect_val("bypnone_pre", 1, 64'h0);
        sample();
        tick();
        wr_en = 1'b0;
        expect_val("bypprio_post", 0, 64'h92);
        expect_val("bypprio_collide", 2, 64'h1);
        sample();

        tick();
        n_tests++;
        if (q_sel.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q_sel.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
